// File: rtl/frodo_pack.sv
// frodo_pack: packs four FrodoKEM coefficients per input word into the
// MSB-first Frodo.Pack bit string. The result is emitted as 64-bit words,
// with stream byte 0 in the lowest lane byte. D (15 or 16) is chosen at
// runtime by config_is16.
module frodo_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        config_is16,
    input  logic [63:0] in,
    input  logic        in_isReady,
    output logic        in_canReceive,
    input  logic        in_isLast,
    output logic [63:0] out,
    output logic        out_isReady,
    input  logic        out_canReceive,
    output logic        out_isLast
);

    typedef enum logic {
        RUN,
        FLUSH
    } packState_e;

    packState_e  state;
    packState_e  stateNext;

    // Stream bit s[k] lives at bitBuf[127-k]. Bits at or past cnt are always
    // zero, so a flushed partial word comes out already zero-padded.
    logic [127:0] bitBuf;
    logic [7:0]   cnt;

    logic [63:0]  packedWord;
    logic [7:0]   pushBits;
    logic         cntHigh;
    logic         push;
    logic         pop;

    assign cntHigh  = (cnt >= 8'd64);
    assign pushBits = config_is16 ? 8'd64 : 8'd60;
    assign push     = in_isReady & in_canReceive;
    assign pop      = out_isReady & out_canReceive;

    // Take the low D bits of each coefficient, MSB first, coefficient 0
    // first. D=15 leaves the word left-aligned with 4 zero tail bits.
    always_comb begin
        if (config_is16) begin
            packedWord = {in[15:0], in[31:16], in[47:32], in[63:48]};
        end else begin
            packedWord = {in[14:0], in[30:16], in[46:32], in[62:48], 4'b0000};
        end
    end

    // Present the head 64 stream bits with the first stream byte in the
    // lowest lane byte. Within each byte, the earliest stream bit is the MSB.
    always_comb begin
        out = '0;
        for (int j = 0; j < 8; j++) begin
            out[8*j +: 8] = bitBuf[127-8*j -: 8];
        end
    end

    // Handshake outputs depend only on state, fill level and out_canReceive.
    always_comb begin
        in_canReceive = 1'b0;
        out_isReady   = 1'b0;
        out_isLast    = 1'b0;
        case (state)
            RUN: begin
                in_canReceive = ~cntHigh | out_canReceive;
                out_isReady   = cntHigh;
            end
            FLUSH: begin
                out_isReady = (cnt != 8'd0);
                out_isLast  = (cnt <= 8'd64);
            end
            default: begin
                in_canReceive = 1'b0;
            end
        endcase
    end

    // Enter FLUSH on accepting the last input word. Return to RUN once the
    // pop that empties the buffer has happened.
    always_comb begin
        stateNext = state;
        case (state)
            RUN: begin
                if (push && in_isLast) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && (cnt <= 8'd64)) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Bit buffer and fill count. A pop shifts the head word out. A push ORs
    // the new bits in at the current tail, which sits after the pop when
    // both happen in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitBuf <= '0;
            cnt    <= 8'd0;
        end else if (pop && push) begin
            bitBuf <= (bitBuf << 64) | ({packedWord, 64'b0} >> (cnt - 8'd64));
            cnt    <= cnt - 8'd64 + pushBits;
        end else if (pop) begin
            bitBuf <= bitBuf << 64;
            cnt    <= (cnt <= 8'd64) ? 8'd0 : (cnt - 8'd64);
        end else if (push) begin
            bitBuf <= bitBuf | ({packedWord, 64'b0} >> cnt);
            cnt    <= cnt + pushBits;
        end
    end

endmodule

// File: tb/tb_frodo_pack.sv
// tb_frodo_pack: directed, self-checking bench for frodo_pack. Inputs change
// 1 ns after the rising edge, and outputs are sampled on the falling edge.
module tb_frodo_pack;

    logic        clk;
    logic        rst;
    logic        config_is16;
    logic [63:0] in;
    logic        in_isReady;
    logic        in_canReceive;
    logic        in_isLast;
    logic [63:0] out;
    logic        out_isReady;
    logic        out_canReceive;
    logic        out_isLast;

    int assertCount;
    int failCount;

    frodo_pack dut (
        .clk            (clk),
        .rst            (rst),
        .config_is16    (config_is16),
        .in             (in),
        .in_isReady     (in_isReady),
        .in_canReceive  (in_canReceive),
        .in_isLast      (in_isLast),
        .out            (out),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive),
        .out_isLast     (out_isLast)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [63:0] word, input logic rdy,
                                 input logic last, input logic outRdy);
        in             = word;
        in_isReady     = rdy;
        in_isLast      = last;
        out_canReceive = outRdy;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // For D=16, each input word maps to one output word: every coefficient
    // appears in place with its two bytes swapped.
    function automatic logic [63:0] swapCoeffs(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[16*i +: 16] = {w[16*i +: 8], w[16*i+8 +: 8]};
        end
        return r;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        int          sent;
        int          outCount;
        int          lastCycle;
        logic [63:0] t4Words [8];
        logic [31:0] stallPattern;
        logic        heldValid;
        logic [63:0] heldWord;
        logic        heldLast;
        logic [7:0]  canRecvExp;
        logic [7:0]  readyExp;

        assertCount = 0;
        failCount   = 0;
        rst         = 1'b0;
        config_is16 = 1'b1;
        applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);

        // Reset values
        nextCycle();
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset out", out, 64'd0);
        checkOutput("reset out_isReady", 64'(out_isReady), 64'd0);
        checkOutput("reset out_isLast", 64'(out_isLast), 64'd0);
        checkOutput("reset in_canReceive", 64'(in_canReceive), 64'd1);
        nextCycle();

        // Test 1: D=16, a single last word
        $display("[TB] test 1: D=16 single word");
        applyStimulus(64'h0004_0003_0002_0001, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t1 accept", 64'(in_canReceive), 64'd1);
        checkOutput("t1 no early output", 64'(out_isReady), 64'd0);
        nextCycle();
        applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1 out", out, 64'h0400_0300_0200_0100);
        checkOutput("t1 out_isReady", 64'(out_isReady), 64'd1);
        checkOutput("t1 out_isLast", 64'(out_isLast), 64'd1);
        checkOutput("t1 flush blocks input", 64'(in_canReceive), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 idle ready", 64'(out_isReady), 64'd0);
        checkOutput("t1 idle canReceive", 64'(in_canReceive), 64'd1);
        checkOutput("t1 idle out", out, 64'd0);
        nextCycle();

        // Test 2: D=15, one padded word
        $display("[TB] test 2: D=15 padded single word");
        config_is16 = 1'b0;
        applyStimulus(64'h0000_0000_0000_4000, 1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2 out", out, 64'h0000_0000_0000_0080);
        checkOutput("t2 out_isReady", 64'(out_isReady), 64'd1);
        checkOutput("t2 out_isLast", 64'(out_isLast), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("t2 drained", 64'(out_isReady), 64'd0);
        nextCycle();

        // Test 3: D=15, 16 all-ones words give 15 all-ones output words
        $display("[TB] test 3: D=15 16-word stream");
        sent      = 0;
        outCount  = 0;
        lastCycle = -1;
        for (int c = 0; c < 20; c++) begin
            if (sent < 16) begin
                applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, (sent == 15), 1'b1);
            end else begin
                applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);
            end
            @(negedge clk);
            if (in_isReady && in_canReceive) begin
                sent++;
            end
            if (out_isReady) begin
                checkOutput("t3 word", out, 64'hFFFF_FFFF_FFFF_FFFF);
                checkOutput("t3 out_isLast", 64'(out_isLast), 64'(outCount == 14));
                outCount++;
                lastCycle = c;
            end
            nextCycle();
        end
        checkOutput("t3 words accepted", 64'(sent), 64'd16);
        checkOutput("t3 words emitted", 64'(outCount), 64'd15);
        checkOutput("t3 last output cycle", 64'(lastCycle), 64'd16);

        // Test 4: D=16, 8 words with downstream stalls
        $display("[TB] test 4: D=16 with stalls");
        config_is16  = 1'b1;
        stallPattern = 32'b1011_0010_1101_1001_0111_0100_1101_0011;
        for (int k = 0; k < 8; k++) begin
            t4Words[k] = 64'h0123_4567_89AB_CDEF + 64'(k) * 64'h1021_3243_5465_7687;
        end
        sent      = 0;
        outCount  = 0;
        heldValid = 1'b0;
        heldWord  = '0;
        heldLast  = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (sent < 8) begin
                applyStimulus(t4Words[sent], 1'b1, (sent == 7), stallPattern[c % 32]);
            end else begin
                applyStimulus(64'd0, 1'b0, 1'b0, stallPattern[c % 32]);
            end
            @(negedge clk);
            if (heldValid) begin
                checkOutput("t4 stall out stable", out, heldWord);
                checkOutput("t4 stall ready stable", 64'(out_isReady), 64'd1);
                checkOutput("t4 stall last stable", 64'(out_isLast), 64'(heldLast));
            end
            if (out_isReady && !out_canReceive) begin
                checkOutput("t4 stall blocks input", 64'(in_canReceive), 64'd0);
            end
            heldValid = out_isReady && !out_canReceive;
            heldWord  = out;
            heldLast  = out_isLast;
            if (in_isReady && in_canReceive) begin
                sent++;
            end
            if (out_isReady && out_canReceive) begin
                if (outCount < 8) begin
                    checkOutput("t4 word", out, swapCoeffs(t4Words[outCount]));
                end
                checkOutput("t4 out_isLast", 64'(out_isLast), 64'(outCount == 7));
                outCount++;
            end
            nextCycle();
        end
        checkOutput("t4 words accepted", 64'(sent), 64'd8);
        checkOutput("t4 words emitted", 64'(outCount), 64'd8);

        // Test 5: reset mid-stream discards the buffer
        $display("[TB] test 5: D=15 reset mid-stream");
        config_is16 = 1'b0;
        sent        = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(64'h1357_2468_ACE0_BDF1, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            if (in_isReady && in_canReceive) begin
                sent++;
            end
            nextCycle();
        end
        checkOutput("t5 words accepted", 64'(sent), 64'd3);
        applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("t5 reset ready", 64'(out_isReady), 64'd0);
        checkOutput("t5 reset out", out, 64'd0);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5 after reset ready", 64'(out_isReady), 64'd0);
        checkOutput("t5 after reset out", out, 64'd0);
        checkOutput("t5 after reset canReceive", 64'(in_canReceive), 64'd1);
        nextCycle();
        applyStimulus(64'h0000_0000_0000_FFFF, 1'b1, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t5 fresh word", out, 64'h0000_0000_0000_FEFF);
        checkOutput("t5 fresh last", 64'(out_isLast), 64'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("t5 nothing more", 64'(out_isReady), 64'd0);
        nextCycle();

        // Test 6: in_isReady held high through a flush
        $display("[TB] test 6: D=15 flush with in_isReady high");
        canRecvExp = 8'b1001_1111;
        readyExp   = 8'b0111_1100;
        sent       = 0;
        outCount   = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, (sent == 4), 1'b1);
            @(negedge clk);
            checkOutput("t6 in_canReceive", 64'(in_canReceive), 64'(canRecvExp[c]));
            checkOutput("t6 out_isReady", 64'(out_isReady), 64'(readyExp[c]));
            if (in_isReady && in_canReceive && sent < 5) begin
                sent++;
            end
            if (out_isReady && out_canReceive) begin
                if (outCount == 4) begin
                    checkOutput("t6 padded word", out, 64'h0000_F0FF_FFFF_FFFF);
                end else begin
                    checkOutput("t6 full word", out, 64'hFFFF_FFFF_FFFF_FFFF);
                end
                checkOutput("t6 out_isLast", 64'(out_isLast), 64'(outCount == 4));
                outCount++;
            end
            nextCycle();
        end
        applyStimulus(64'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("t6 words emitted", 64'(outCount), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
